wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Write-back stage directly downstream of the memory stage. It commits the memory stage's register-file and CSR writes, and holds the 32x64 integer register file and the machine-mode CSR file. It provides combinational read ports to decode and runs a RUN/HALT state machine driven by the debug exit flag. It also maintains the mcycle and minstret counters.

Parameters:
NREGS, 32, number of integer registers (x0 hardwired zero)
XLEN, 64, data width

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clock)
valid_i  in  1  memory-stage output holds a retiring instruction this cycle
wen_i  in  1  regfile write enable
rd_i  in  5  destination register
wdata_i  in  64  regfile write data
csr_wen_i  in  1  CSR write enable
csr_addr_i  in  12  CSR write address
csr_wdata_i  in  64  CSR write data
pc_i  in  64  pc of retiring instruction
exit_i  in  1  retiring instruction is the simulation-exit marker
rs1_i  in  5  read port 1 address
rs2_i  in  5  read port 2 address
rdata1_o  out  64  read port 1 data
rdata2_o  out  64  read port 2 data
csr_raddr_i  in  12  CSR read address
csr_rdata_o  out  64  CSR read data
mtvec_o  out  64  current mtvec
mepc_o  out  64  current mepc
halted_o  out  1  state == HALT
exit_code_o  out  64  value of x10 captured at exit
exit_pc_o  out  64  pc of exiting instruction
retire_o  out  1  registered pulse, one instruction committed previous cycle

Behaviour:
- Reset (reset==0 at posedge): state RUN. All regs x1..x31 = 0. All CSRs = 0 (mstatus.MPP reads 2'b11 regardless). Counters = 0. halted_o=0, exit_code_o=0, exit_pc_o=0, retire_o=0. Reset overrides all simultaneous inputs, including a mid-HALT reset.
- Commit condition: commit = valid_i && state==RUN. All writes take effect at the posedge of the commit cycle; latency 1.
- Regfile: write when commit && wen_i && rd_i!=0. Writes to x0 are dropped; x0 always reads 0.
- Reads: rdata1_o/rdata2_o are combinational from the array; see WB_BYPASS_EN.
- CSRs implemented:
  - mstatus 0x300: writable bits MIE[3], MPIE[7]; MPP[12:11] reads 11; all other bits read 0.
  - mtvec 0x305: bits[1:0] forced 0.
  - mepc 0x341: bits[1:0] forced 0.
  - mcause 0x342: full 64-bit.
  - mcycle 0xB00.
  - minstret 0xB02.
- CSR write when commit && csr_wen_i. Writes to unimplemented addresses are ignored. Reads of unimplemented addresses return 0. csr_rdata_o is combinational and returns the pre-write value.
- mcycle: +1 every cycle while in RUN. minstret: +1 each commit. Both wrap modulo 2^64.
- Counter vs CSR write in the same cycle: the CSR write value wins and that cycle's increment is discarded.
- State machine:
  - RUN -> HALT at the posedge where commit && exit_i. The exiting instruction's own regfile/CSR writes commit.
  - On that edge: exit_pc_o <= pc_i. exit_code_o <= (wen_i && rd_i==10) ? wdata_i : x10.
  - HALT is sticky until reset. In HALT: no writes, counters frozen, valid_i ignored, read ports remain functional.
- retire_o <= commit, a 1-cycle pulse per committed instruction.
- mtvec_o and mepc_o reflect registered CSR values, not bypassed.

Optional Feature:
WB_BYPASS_EN
- Defined: write-through forwarding. If commit && wen_i && rd_i!=0 && rs1_i==rd_i, rdata1_o = wdata_i (same for port 2). Same-cycle CSR read/write to the same address returns csr_wdata_i with masking applied.
- Undefined: read ports return the array contents only, i.e. pre-write values. Decode must handle the hazard itself.

Test Plan:
- Reset low 2 cycles, then high; read rs1=5, csr 0xB02 -> rdata1_o=0, csr_rdata_o=0, halted_o=0, mcycle counts 1,2,3 on subsequent cycles.
- valid=1 wen=1 rd=0 wdata=0xDEAD, then valid=1 wen=1 rd=7 wdata=0x1234 -> x0 reads 0; x7 reads 0x1234 next cycle; minstret=2; retire_o pulses twice.
- Same cycle: csr_wen to 0xB02 with data 100 and valid=1 -> minstret=100 (not 101). Write mtvec 0x80000003 -> reads 0x80000000. Write mstatus all-ones -> reads 0x1888.
- Set x10=0x2A; exit_i=1 with pc=0x80000100 and wen rd=10 wdata=0x7 -> halted_o=1, exit_code_o=0x7, exit_pc_o=0x80000100. Subsequent valid writes to x3 ignored; mcycle frozen.
- While halted, pull reset low 1 cycle -> halted_o=0, x10=0, exit_code_o=0, counters restart from 0.
- WB_BYPASS_EN defined: write rd=4 data 0x55 with rs1_i=4 in the same cycle -> rdata1_o=0x55 combinationally. Undefined: rdata1_o shows the old value (0) that cycle and 0x55 the next cycle.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: write-back commit, 32x64 regfile, M-mode CSRs, mcycle/minstret, RUN/HALT on exit.
// Define WB_BYPASS_EN for write-through forwarding on the regfile and CSR read ports.
module wb_stage #(
  parameter int NREGS = 32,
  parameter int XLEN  = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            wen_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            csr_wen_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [63:0]     csr_wdata_i,
  input  logic [63:0]     pc_i,
  input  logic            exit_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o,
  input  logic [11:0]     csr_raddr_i,
  output logic [63:0]     csr_rdata_o,
  output logic [63:0]     mtvec_o,
  output logic [63:0]     mepc_o,
  output logic            halted_o,
  output logic [63:0]     exit_code_o,
  output logic [63:0]     exit_pc_o,
  output logic            retire_o
);
  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;

  logic            state;
  logic [XLEN-1:0] regs [NREGS];
  logic            mie, mpie;
  logic [63:0]     mtvec, mepc, mcause, mcycle, minstret;
  logic            commit, wr, cw;
  logic [63:0]     csr_stored, csr_wmask;

  assign commit   = valid_i && state == RUN;
  assign wr       = commit && wen_i && rd_i != 5'd0;
  assign cw       = commit && csr_wen_i;
  assign halted_o = state == HALT;
  assign mtvec_o  = mtvec;
  assign mepc_o   = mepc;

  always_comb begin
    csr_stored = csr_raddr_i == A_MSTATUS  ? {51'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0} :
                 csr_raddr_i == A_MTVEC    ? mtvec :
                 csr_raddr_i == A_MEPC     ? mepc :
                 csr_raddr_i == A_MCAUSE   ? mcause :
                 csr_raddr_i == A_MCYCLE   ? mcycle :
                 csr_raddr_i == A_MINSTRET ? minstret : 64'b0;
    csr_wmask  = csr_addr_i == A_MSTATUS  ? (csr_wdata_i & 64'h88) | 64'h1800 :
                 csr_addr_i == A_MTVEC || csr_addr_i == A_MEPC ? {csr_wdata_i[63:2], 2'b00} :
                 csr_addr_i == A_MCAUSE || csr_addr_i == A_MCYCLE ||
                 csr_addr_i == A_MINSTRET ? csr_wdata_i : 64'b0;
`ifdef WB_BYPASS_EN
    rdata1_o    = wr && rs1_i == rd_i ? wdata_i : regs[rs1_i];
    rdata2_o    = wr && rs2_i == rd_i ? wdata_i : regs[rs2_i];
    csr_rdata_o = cw && csr_addr_i == csr_raddr_i ? csr_wmask : csr_stored;
`else
    rdata1_o    = regs[rs1_i];
    rdata2_o    = regs[rs2_i];
    csr_rdata_o = csr_stored;
`endif
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= RUN;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      mie         <= 1'b0;
      mpie        <= 1'b0;
      mtvec       <= '0;
      mepc        <= '0;
      mcause      <= '0;
      mcycle      <= '0;
      minstret    <= '0;
      exit_code_o <= '0;
      exit_pc_o   <= '0;
      retire_o    <= 1'b0;
    end else begin
      retire_o <= commit;
      if (wr) regs[rd_i] <= wdata_i;
      if (state == RUN) mcycle <= mcycle + 64'd1;
      if (commit) minstret <= minstret + 64'd1;
      // later assignments let an explicit CSR write override the counter increment
      if (cw && csr_addr_i == A_MSTATUS) begin
        mie  <= csr_wdata_i[3];
        mpie <= csr_wdata_i[7];
      end
      if (cw && csr_addr_i == A_MTVEC) mtvec <= csr_wmask;
      if (cw && csr_addr_i == A_MEPC) mepc <= csr_wmask;
      if (cw && csr_addr_i == A_MCAUSE) mcause <= csr_wdata_i;
      if (cw && csr_addr_i == A_MCYCLE) mcycle <= csr_wdata_i;
      if (cw && csr_addr_i == A_MINSTRET) minstret <= csr_wdata_i;
      if (commit && exit_i) begin
        state       <= HALT;
        exit_pc_o   <= pc_i;
        exit_code_o <= wen_i && rd_i == 5'd10 ? wdata_i : regs[10];
      end
    end
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed checks of wb_stage commit, CSRs, counters, halt and reset.
module tb_wb_stage;
  logic        clock, reset, valid_i, wen_i, csr_wen_i, exit_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [63:0] wdata_i, csr_wdata_i, pc_i;
  logic [11:0] csr_addr_i, csr_raddr_i;
  logic [63:0] rdata1_o, rdata2_o, csr_rdata_o, mtvec_o, mepc_o, exit_code_o, exit_pc_o;
  logic        halted_o, retire_o;
  int          errors = 0, checks = 0;
  logic [63:0] exp_cyc;
  logic        exp_halt;

  wb_stage dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .wen_i(wen_i), .rd_i(rd_i),
    .wdata_i(wdata_i), .csr_wen_i(csr_wen_i), .csr_addr_i(csr_addr_i),
    .csr_wdata_i(csr_wdata_i), .pc_i(pc_i), .exit_i(exit_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .rdata1_o(rdata1_o), .rdata2_o(rdata2_o), .csr_raddr_i(csr_raddr_i),
    .csr_rdata_o(csr_rdata_o), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .halted_o(halted_o),
    .exit_code_o(exit_code_o), .exit_pc_o(exit_pc_o), .retire_o(retire_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    if (!exp_halt) exp_cyc = exp_cyc + 64'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; wen_i = 0; csr_wen_i = 0; exit_i = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
    valid_i = 1; csr_wen_i = 1; csr_addr_i = a; csr_wdata_i = d;
    step();
    idle();
    #1;
  endtask

  initial begin
    reset = 0; idle(); rd_i = 0; wdata_i = 0; csr_addr_i = 0; csr_wdata_i = 0; pc_i = 0;
    rs1_i = 5; rs2_i = 0; csr_raddr_i = 12'hB02; exp_cyc = 0; exp_halt = 0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1; #1;
    chk("rst_rdata1", rdata1_o, 0);
    chk("rst_minstret", csr_rdata_o, 0);
    chk("rst_halted", {63'b0, halted_o}, 0);
    chk("rst_retire", {63'b0, retire_o}, 0);
    chk("rst_exit_code", exit_code_o, 0);
    chk("rst_exit_pc", exit_pc_o, 0);
    csr_raddr_i = 12'h300; #1;
    chk("rst_mstatus", csr_rdata_o, 64'h1800);
    csr_raddr_i = 12'hB00; #1;
    chk("rst_mcycle", csr_rdata_o, 0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("mcycle_count", csr_rdata_o, exp_cyc);
    end
    chk("mcycle_model", exp_cyc, 64'd3);

    valid_i = 1; wen_i = 1; rd_i = 0; wdata_i = 64'hDEAD;
    step();
    chk("retire_1", {63'b0, retire_o}, 1);
    rd_i = 7; wdata_i = 64'h1234; rs1_i = 0; #1;
    chk("x0_zero", rdata1_o, 0);
    step();
    idle(); rs1_i = 7; csr_raddr_i = 12'hB02; #1;
    chk("x7", rdata1_o, 64'h1234);
    chk("retire_2", {63'b0, retire_o}, 1);
    chk("minstret_2", csr_rdata_o, 2);
    step();
    chk("retire_idle", {63'b0, retire_o}, 0);

    csr_wr(12'hB02, 64'd100);
    chk("minstret_csr_wins", csr_rdata_o, 100);
    csr_wr(12'h305, 64'h80000003);
    chk("mtvec_o", mtvec_o, 64'h80000000);
    csr_raddr_i = 12'h305; #1;
    chk("mtvec_rd", csr_rdata_o, 64'h80000000);
    csr_wr(12'h300, '1);
    csr_raddr_i = 12'h300; #1;
    chk("mstatus_mask", csr_rdata_o, 64'h1888);
    csr_wr(12'h341, 64'h80000007);
    chk("mepc_o", mepc_o, 64'h80000004);
    csr_wr(12'h342, '1);
    csr_raddr_i = 12'h342; #1;
    chk("mcause", csr_rdata_o, '1);
    csr_wr(12'h123, 64'h55);
    csr_raddr_i = 12'h123; #1;
    chk("unimpl", csr_rdata_o, 0);
    csr_raddr_i = 12'hB02; #1;
    chk("minstret_105", csr_rdata_o, 105);

    valid_i = 1; wen_i = 1; rd_i = 10; wdata_i = 64'h2A;
    step();
    rs1_i = 10; #1;
    chk("x10_set", rdata1_o, 64'h2A);
    wdata_i = 64'h7; exit_i = 1; pc_i = 64'h80000100;
    step();
    exp_halt = 1; idle(); #1;
    chk("halted", {63'b0, halted_o}, 1);
    chk("exit_code", exit_code_o, 64'h7);
    chk("exit_pc", exit_pc_o, 64'h80000100);
    chk("exit_wr_commits", rdata1_o, 64'h7);
    chk("minstret_exit", csr_rdata_o, 107);
    valid_i = 1; wen_i = 1; rd_i = 3; wdata_i = 64'h99; rs2_i = 3;
    csr_wen_i = 1; csr_addr_i = 12'hB02; csr_wdata_i = 64'h9;
    step(); step();
    chk("halt_no_write", rdata2_o, 0);
    chk("halt_no_retire", {63'b0, retire_o}, 0);
    chk("halt_minstret", csr_rdata_o, 107);
    csr_raddr_i = 12'hB00; #1;
    chk("halt_mcycle", csr_rdata_o, exp_cyc);
    chk("halt_sticky", {63'b0, halted_o}, 1);

    reset = 0;
    step();
    reset = 1; exp_cyc = 0; exp_halt = 0; idle(); #1;
    chk("rerst_halted", {63'b0, halted_o}, 0);
    chk("rerst_x10", rdata1_o, 0);
    chk("rerst_exit_code", exit_code_o, 0);
    chk("rerst_exit_pc", exit_pc_o, 0);
    chk("rerst_mcycle", csr_rdata_o, 0);
    csr_raddr_i = 12'hB02; #1;
    chk("rerst_minstret", csr_rdata_o, 0);
    csr_raddr_i = 12'hB00;
    step();
    chk("rerst_mcycle_1", csr_rdata_o, 1);

    valid_i = 1; wen_i = 1; rd_i = 4; wdata_i = 64'h55; rs1_i = 4;
    csr_wen_i = 1; csr_addr_i = 12'h305; csr_wdata_i = 64'h103; csr_raddr_i = 12'h305; #1;
`ifdef WB_BYPASS_EN
    chk("bypass_rs1", rdata1_o, 64'h55);
    chk("bypass_csr", csr_rdata_o, 64'h100);
`else
    chk("nobypass_rs1", rdata1_o, 0);
    chk("nobypass_csr", csr_rdata_o, 0);
`endif
    step();
    idle(); #1;
    chk("x4_next", rdata1_o, 64'h55);
    chk("mtvec_next", csr_rdata_o, 64'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
